// File: rtl/nn_cls_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nn_cls_pkg
//  Purpose : Shared definitions for the classifier sequencer: Q6.10 format
//            constants, class index encoding, sequencer state encoding and
//            the default attack threshold.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package nn_cls_pkg;

  // Q6.10 signed fixed point: 6 integer bits (incl. sign), 10 fraction bits
  localparam int c_data_width = 16;
  localparam int c_q_frac     = 10;
  localparam int c_n_lanes    = 4;

  // 2.5 in Q6.10
  localparam logic [15:0] c_thresh_default = 16'h0A00;

  // Lane i of the core scores class i
  typedef enum logic [1:0] {
    CLS_DOS      = 2'd0,
    CLS_PORTSCAN = 2'd1,
    CLS_DDOS     = 2'd2,
    CLS_PATATOR  = 2'd3
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_START  = 3'd2,
    ST_STREAM = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DECIDE = 3'd5,
    ST_HOLD   = 3'd6
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/nn_argmax4.sv
`default_nettype none
// ============================================================================
//  Module  : nn_argmax4
//  Purpose : Combinational signed 4-way maximum. On equal scores the lowest
//            lane index wins.
//  Ports   : scores  [4*DATA_WIDTH] in  {s3,s2,s1,s0}, lane 0 in the LSBs
//            max_idx [2]            out index of the winning lane
//            max_val [DATA_WIDTH]   out winning score
//  Revision: 1.0 - initial release
// ============================================================================
module nn_argmax4 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [4*DATA_WIDTH-1:0] scores,
  output logic [1:0]              max_idx,
  output logic [DATA_WIDTH-1:0]   max_val
);

  // Strict greater-than keeps the earlier (lower) lane on a tie.
  always_comb begin
    max_idx = 2'd0;
    max_val = scores[DATA_WIDTH-1:0];
    for (int i = 1; i < 4; i++) begin
      if ($signed(scores[i*DATA_WIDTH +: DATA_WIDTH]) > $signed(max_val)) begin
        max_idx = 2'(i);
        max_val = scores[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_classify_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : nn_classify_sequencer
//  Purpose : Controller for the 4-lane forward classifier core. Buffers one
//            feature vector, streams x_j with per-lane weights into the core,
//            waits for the core result, picks the winning class and flags an
//            attack when the winning score exceeds THRESH.
//  Ports   : clk, rst (async, active-low)
//            feat_valid/feat_ready/feat_data/feat_last : feature stream in
//            wt_addr/wt_data     : weight ROM (data valid 1 cycle after addr)
//            core_start/core_clr : core control pulses
//            core_x/core_w       : operand broadcast and per-lane weights
//            core_done/core_score: core result (level) and 4 lane scores
//            res_valid/res_ready/res_class/res_score/res_attack/res_err :
//                                  result channel
//  Revision: 1.0 - initial release
// ============================================================================
module nn_classify_sequencer
  import nn_cls_pkg::*;
#(
  parameter int                    DATA_WIDTH = c_data_width,
  parameter int                    N_FEAT     = 12,
  parameter int                    ADDR_W     = 4,
  parameter int                    TIMEOUT    = 64,
  parameter logic [DATA_WIDTH-1:0] THRESH     = DATA_WIDTH'(c_thresh_default)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    feat_valid,
  output logic                    feat_ready,
  input  logic [DATA_WIDTH-1:0]   feat_data,
  input  logic                    feat_last,
  output logic [ADDR_W-1:0]       wt_addr,
  input  logic [4*DATA_WIDTH-1:0] wt_data,
  output logic                    core_start,
  output logic                    core_clr,
  output logic [4*DATA_WIDTH-1:0] core_x,
  output logic [4*DATA_WIDTH-1:0] core_w,
  input  logic                    core_done,
  input  logic [4*DATA_WIDTH-1:0] core_score,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_class,
  output logic [DATA_WIDTH-1:0]   res_score,
  output logic                    res_attack,
  output logic                    res_err
);

  localparam int c_cnt_w  = $clog2(N_FEAT + 1);
  localparam int c_idx_w  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_cnt_w-1:0]  c_n_feat    = c_cnt_w'(N_FEAT);
  localparam logic [c_cnt_w-1:0]  c_last_k    = c_cnt_w'(N_FEAT - 1);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

  seq_state_e              r_state;
  logic [c_cnt_w-1:0]      r_cnt;     // words stored in FILL, feature index k in STREAM
  logic [c_wait_w-1:0]     r_wait;
  logic [DATA_WIDTH-1:0]   r_buf [N_FEAT];
  logic [DATA_WIDTH-1:0]   r_x;
  logic [4*DATA_WIDTH-1:0] r_score;

  logic                    w_feat_acc;
  logic [c_cnt_w-1:0]      w_cnt_sat;
  logic [1:0]              w_max_idx;
  logic [DATA_WIDTH-1:0]   w_max_val;

  assign w_feat_acc = feat_valid && feat_ready;

  // Count including the word being accepted; saturates so that words past
  // N_FEAT are dropped while a final feat_last still sees a full vector.
  assign w_cnt_sat = (r_cnt == c_n_feat) ? r_cnt : r_cnt + c_cnt_w'(1);

  // Same x_j goes to every MAC lane.
  genvar g;
  for (g = 0; g < c_n_lanes; g++) begin : g_lane
    assign core_x[g*DATA_WIDTH +: DATA_WIDTH] = r_x;
  end

  nn_argmax4 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_argmax (
    .scores  (r_score),
    .max_idx (w_max_idx),
    .max_val (w_max_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_x        <= '0;
      r_score    <= '0;
      for (int i = 0; i < N_FEAT; i++) begin
        r_buf[i] <= '0;
      end
      feat_ready <= 1'b0;
      wt_addr    <= '0;
      core_start <= 1'b0;
      core_clr   <= 1'b0;
      core_w     <= '0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_score  <= '0;
      res_attack <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      // Pulses and operands are only live in the states that set them.
      core_start <= 1'b0;
      core_clr   <= 1'b0;
      r_x        <= '0;
      core_w     <= '0;

      case (r_state)
        ST_IDLE, ST_FILL: begin
          feat_ready <= 1'b1;
          if (w_feat_acc) begin
            if (r_cnt < c_n_feat) begin
              r_buf[r_cnt[c_idx_w-1:0]] <= feat_data;
            end
            r_cnt <= w_cnt_sat;
            if (feat_last) begin
              feat_ready <= 1'b0;
              if (w_cnt_sat == c_n_feat) begin
                // Address 0 goes out with the start pulse so that w_0 is
                // on wt_data in the first STREAM cycle.
                r_state    <= ST_START;
                core_start <= 1'b1;
                wt_addr    <= '0;
              end else begin
                r_state    <= ST_HOLD;
                res_valid  <= 1'b1;
                res_err    <= 1'b1;
                res_class  <= CLS_DOS;
                res_score  <= '0;
                res_attack <= 1'b0;
              end
            end else begin
              r_state <= ST_FILL;
            end
          end
        end

        ST_START: begin
          r_state <= ST_STREAM;
          r_cnt   <= '0;
          wt_addr <= ADDR_W'(1);
        end

        ST_STREAM: begin
          // wt_data now holds w_k (addressed last cycle); registering it with
          // buf[k] keeps x_k and w_k aligned on the core inputs.
          r_x    <= r_buf[r_cnt[c_idx_w-1:0]];
          core_w <= wt_data;
          if (r_cnt == c_last_k) begin
            r_state <= ST_WAIT;
            r_wait  <= '0;
            wt_addr <= '0;
          end else begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
            wt_addr <= ADDR_W'(r_cnt) + ADDR_W'(2);
          end
        end

        ST_WAIT: begin
          if (core_done) begin
            r_score <= core_score;
            r_state <= ST_DECIDE;
          end else if (r_wait == c_wait_last) begin
            core_clr   <= 1'b1;
            r_state    <= ST_HOLD;
            res_valid  <= 1'b1;
            res_err    <= 1'b1;
            res_class  <= CLS_DOS;
            res_score  <= '0;
            res_attack <= 1'b0;
          end else begin
            r_wait <= r_wait + c_wait_w'(1);
          end
        end

        ST_DECIDE: begin
          r_state    <= ST_HOLD;
          res_valid  <= 1'b1;
          res_err    <= 1'b0;
          res_class  <= w_max_idx;
          res_score  <= w_max_val;
          res_attack <= ($signed(w_max_val) > $signed(THRESH));
        end

        ST_HOLD: begin
          // res_valid is always high here; leave only on the handshake.
          if (res_ready) begin
            r_state    <= ST_IDLE;
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_score  <= '0;
            res_attack <= 1'b0;
            res_err    <= 1'b0;
            r_cnt      <= '0;
            feat_ready <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
